// File: rtl/test1.sv
// SRAM loader: a 16x32 FIFO drained into an 8192x32 SRAM by a small FSM,
// with a micro port that owns the SRAM whenever micro_control is low.
module test1 (
  input  logic        test1_clk_i,
  input  logic        test1_rst_i,
  input  logic [12:0] micro_sram_address_i,
  input  logic [31:0] micro_sram_datain_i,
  input  logic        micro_sram_cs_i,
  input  logic        micro_sram_we_i,
  input  logic        micro_control,
  input  logic        write_mem_init_i,
  input  logic        fifo_writeflag_i,
  input  logic [31:0] fifo_writedata_i,
  output logic        flag_writefinish_o,
  output logic        fifo_fullflag_o,
  output logic [31:0] sram_data_o
);

  // state    | meaning
  // ST_IDLE  | waiting for micro_control=1 and write_mem_init_i=1
  // ST_WRITE | popping one FIFO word per cycle into SRAM
  // ST_DONE  | FIFO drained, finish flag high until request drops
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] fifo_mem [16];
  logic [31:0] sram_mem [8192];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  count;
  logic        flag_d;
  logic [12:0] ld_addr;
  logic        push, pop, fifo_empty, start, micro_wr, micro_rd;

  assign fifo_empty      = (count == 5'd0);
  assign fifo_fullflag_o = (count == 5'd16);
  assign push            = fifo_writeflag_i & ~flag_d & ~fifo_fullflag_o;
  assign pop             = (state == ST_WRITE) & micro_control & ~fifo_empty;
  assign start           = (state == ST_IDLE) & micro_control & write_mem_init_i;
  assign micro_wr        = ~micro_control & ~micro_sram_cs_i & ~micro_sram_we_i;
  assign micro_rd        = ~micro_control & ~micro_sram_cs_i &  micro_sram_we_i;

  always_ff @(posedge test1_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= fifo_writedata_i;
  end

  always_ff @(posedge test1_clk_i or posedge test1_rst_i) begin
    if (test1_rst_i) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
      flag_d <= 1'b0;
    end else begin
      flag_d <= fifo_writeflag_i;
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge test1_clk_i or posedge test1_rst_i) begin
    if (test1_rst_i) begin
      ld_addr <= 13'd0;
    end else if (start) begin
      ld_addr <= 13'd0;
    end else if (pop) begin
      ld_addr <= ld_addr + 13'd1;
    end
  end

  // SRAM array has no reset; loader and micro writes are mutually exclusive via micro_control
  always_ff @(posedge test1_clk_i) begin
    if (pop) begin
      sram_mem[ld_addr] <= fifo_mem[rd_ptr];
    end else if (micro_wr) begin
      sram_mem[micro_sram_address_i] <= micro_sram_datain_i;
    end
  end

  always_ff @(posedge test1_clk_i or posedge test1_rst_i) begin
    if (test1_rst_i) begin
      sram_data_o <= 32'd0;
    end else if (micro_rd) begin
      sram_data_o <= sram_mem[micro_sram_address_i];
    end
  end

  always_ff @(posedge test1_clk_i or posedge test1_rst_i) begin
    if (test1_rst_i) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (!micro_control)  state_nxt = ST_IDLE;
        else if (fifo_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!micro_control || !write_mem_init_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    flag_writefinish_o = 1'b0;
    if (state == ST_DONE) flag_writefinish_o = 1'b1;
  end

endmodule

// File: tb/tb_test1.sv
// Scoreboard bench for test1: micro reads queue their expected word, a monitor
// compares sram_data_o one cycle later; flag checks are made inline.
module tb_test1;

  logic        clk;
  logic        rst;
  logic [12:0] addr;
  logic [31:0] datain;
  logic        cs, we, mc, init, wflag;
  logic [31:0] wdata;
  logic        finish, full;
  logic [31:0] rdata;

  logic [31:0] exp_q[$];
  logic        rd_v;
  int          n_pass, n_total;
  int          k;

  test1 dut (
    .test1_clk_i          (clk),
    .test1_rst_i          (rst),
    .micro_sram_address_i (addr),
    .micro_sram_datain_i  (datain),
    .micro_sram_cs_i      (cs),
    .micro_sram_we_i      (we),
    .micro_control        (mc),
    .write_mem_init_i     (init),
    .fifo_writeflag_i     (wflag),
    .fifo_writedata_i     (wdata),
    .flag_writefinish_o   (finish),
    .fifo_fullflag_o      (full),
    .sram_data_o          (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // A read issued before a rising edge presents its data after that edge.
  always @(posedge clk) rd_v <= !rst && !mc && !cs && we;

  always @(negedge clk) begin
    if (rd_v) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_read: got %h expected none", rdata);
      end else begin
        check("sb_read", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic mwrite(input logic [12:0] a, input logic [31:0] d);
    mc = 1'b0; cs = 1'b0; we = 1'b0; addr = a; datain = d;
    @(negedge clk);
    cs = 1'b1; we = 1'b1;
  endtask

  task automatic mread(input logic [12:0] a, input logic [31:0] e);
    mc = 1'b0; cs = 1'b0; we = 1'b1; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    cs = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d, input int hi, input int lo);
    wflag = 1'b1; wdata = d;
    repeat (hi) @(negedge clk);
    wflag = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Holds the drain request for 'hold' cycles; kk = cycles until finish first seen (0 = never).
  task automatic drain(input int hold, output int kk);
    mc = 1'b1; init = 1'b1; kk = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (finish && kk == 0) kk = i;
    end
    init = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; rd_v = 1'b0;
    rst = 1'b1; addr = '0; datain = '0; cs = 1'b1; we = 1'b1;
    mc = 1'b1; init = 1'b0; wflag = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_finish", {31'd0, finish}, 32'd0);
    check("reset_full", {31'd0, full}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Session 1: marker at 4 catches extra pushes from a held-high flag.
    mwrite(13'd4, 32'h5555_5555);
    mc = 1'b1;
    push_word(32'hADAD_0011, 2, 2);
    push_word(32'h000A_0201, 2, 2);
    push_word(32'h0000_0001, 2, 2);
    push_word(32'hABCD_1234, 2, 2);
    check("four_pushes_not_full", {31'd0, full}, 32'd0);
    drain(20, k);
    check("s1_finish_cycle", k, 6);
    check("s1_finish_cleared", {31'd0, finish}, 32'd0);
    check("s1_fifo_not_full", {31'd0, full}, 32'd0);
    mread(13'd0, 32'hADAD_0011);
    mread(13'd1, 32'h000A_0201);
    mread(13'd2, 32'h0000_0001);
    mread(13'd3, 32'hABCD_1234);
    mread(13'd4, 32'h5555_5555);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h5555_5555);

    // Session 2: 17 pushes, the 17th must be dropped.
    mwrite(13'd16, 32'hCAFE_0016);
    mc = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'h0000_1000 + i, 1, 1);
    check("full_after_16", {31'd0, full}, 32'd1);
    push_word(32'h0000_1010, 1, 1);
    check("full_after_17", {31'd0, full}, 32'd1);
    drain(25, k);
    check("s2_finish_cycle", k, 18);
    check("s2_fifo_not_full", {31'd0, full}, 32'd0);
    mread(13'd0,  32'h0000_1000);
    mread(13'd5,  32'h0000_1005);
    mread(13'd15, 32'h0000_100F);
    mread(13'd16, 32'hCAFE_0016);

    // Micro port at top address, ownership and chip-select gating.
    mwrite(13'h1FFF, 32'h0000_BEEF);
    mread(13'h1FFF, 32'h0000_BEEF);
    mc = 1'b1; cs = 1'b0; we = 1'b0; addr = 13'h1FFF; datain = 32'hDEAD_0000;
    @(negedge clk);
    we = 1'b1; addr = 13'd0;
    @(negedge clk);
    cs = 1'b1;
    check("read_ignored_when_loader", rdata, 32'h0000_BEEF);
    mc = 1'b0; cs = 1'b1; we = 1'b0; addr = 13'h1FFF; datain = 32'h1234_5678;
    @(negedge clk);
    we = 1'b1;
    mread(13'h1FFF, 32'h0000_BEEF);

    // Reset while in WRITE with a full FIFO, before any pop.
    mc = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'h0000_7000 + i, 1, 1);
    check("refill_full", {31'd0, full}, 32'd1);
    init = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_full", {31'd0, full}, 32'd0);
    check("async_rst_finish", {31'd0, finish}, 32'd0);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drain(5, k);
    check("post_rst_empty_drain", k, 2);
    mread(13'd0, 32'h0000_1000);

    // Reset while in DONE drops the finish flag without a clock edge.
    mc = 1'b1; init = 1'b1;
    repeat (3) @(negedge clk);
    check("done_finish_high", {31'd0, finish}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_done_finish", {31'd0, finish}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/test1.md
TEST1 -- requirements
Module: test1

Interface
REQ-001 Parameters: none; FIFO depth fixed at 16 words x 32 bits; SRAM fixed at 8192 words x 32 bits.
REQ-002 test1_clk_i  in  1  sole clock; all state changes on rising edge.
REQ-003 test1_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 micro_sram_address_i  in  13  micro-side SRAM word address.
REQ-005 micro_sram_datain_i  in  32  micro-side SRAM write data.
REQ-006 micro_sram_cs_i  in  1  micro chip select, active-low.
REQ-007 micro_sram_we_i  in  1  micro write enable, active-low (1 = read).
REQ-008 micro_control  in  1  SRAM owner select: 1 = loader (FIFO path), 0 = micro port.
REQ-009 write_mem_init_i  in  1  level request to drain FIFO into SRAM.
REQ-010 fifo_writeflag_i  in  1  FIFO push request, rising-edge sensitive.
REQ-011 fifo_writedata_i  in  32  FIFO push data.
REQ-012 flag_writefinish_o  out  1  drain complete.
REQ-013 fifo_fullflag_o  out  1  FIFO holds 16 words.
REQ-014 sram_data_o  out  32  registered SRAM read data.

Function
REQ-015 Push: fifo_writeflag_i sampled each cycle; exactly one word (fifo_writedata_i) pushed on the cycle it is seen 1 after being 0; holding it high pushes nothing further.
REQ-016 Push when full is ignored; count and contents unchanged.
REQ-017 fifo_fullflag_o = (count == 16), combinational from registered count.
REQ-018 FIFO pointers 4-bit, wrap 15 -> 0; simultaneous push and pop keeps count unchanged and both take effect.
REQ-019 Loader FSM states IDLE, WRITE, DONE.
REQ-020 IDLE: if micro_control=1 and write_mem_init_i=1 -> WRITE, loader address cleared to 0.
REQ-021 WRITE: per cycle, if FIFO non-empty, pop head word, write it to SRAM[loader address], increment address (13-bit, wraps 8191 -> 0); if FIFO empty -> DONE.
REQ-022 DONE: flag_writefinish_o=1; when write_mem_init_i=0 -> IDLE.
REQ-023 flag_writefinish_o=0 in IDLE and WRITE.
REQ-024 micro_control=0 in WRITE or DONE -> IDLE immediately; words already written remain.
REQ-025 Pushes during WRITE allowed; pushed words are drained in the same session if they arrive before FIFO goes empty.
REQ-026 Micro port active only when micro_control=0; ignored otherwise.
REQ-027 Micro write: cs=0, we=0 -> SRAM[address] <= datain on the clock edge.
REQ-028 Micro read: cs=0, we=1 -> sram_data_o <= SRAM[address] on the clock edge (1-cycle latency).
REQ-029 sram_data_o holds its last value when no micro read occurs.
REQ-030 cs=1 -> no SRAM access from micro port.

Reset
REQ-031 Reset clears FIFO pointers/count, push edge-detect register, loader address, FSM -> IDLE, sram_data_o -> 0, flag_writefinish_o -> 0, fifo_fullflag_o -> 0.
REQ-032 SRAM contents are not cleared by reset.
REQ-033 Reset mid-drain aborts the session; undrained FIFO words are discarded.

Verification
REQ-034 Reset, micro_control=1, four pushes (each flag high 2 cycles, low 2) of ADAD0011, 000A0201, 00000001, ABCD1234 -> count 4, fifo_fullflag_o=0.
REQ-035 Then write_mem_init_i=1 for 20 cycles -> SRAM[0..3] = ADAD0011, 000A0201, 00000001, ABCD1234; flag_writefinish_o=1 within 6 cycles; FIFO empty.
REQ-036 write_mem_init_i=0, micro_control=0, cs=0 we=1 one cycle at addresses 0,1,2 -> sram_data_o = ADAD0011, 000A0201, 00000001 one cycle after each.
REQ-037 17 single pushes -> fifo_fullflag_o=1 after 16th; 17th word absent after drain (SRAM[16] untouched).
REQ-038 Micro write 0000BEEF to address 0x1FFF (cs=0, we=0), then read -> sram_data_o = 0000BEEF; with micro_control=1 the same write has no effect.
REQ-039 Assert test1_rst_i asynchronously mid-drain -> flag_writefinish_o=0, FSM IDLE, FIFO empty immediately, without waiting for a clock edge.
